fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter in front of an asynchronous FIFO's write side.
// Several requesters share the single FIFO write port. One requester at a time
// owns a burst of up to MAXBURST words. Arbitration takes one IDLE cycle. The
// search starts just after the previous owner.
//
// Ports
//   wclk     : write-domain clock, all state updates on its rising edge
//   wrst     : asynchronous active-high reset
//   req      : per-requester "word ready" flags
//   req_data : requester i word at [i*DSIZE +: DSIZE]
//   wfull    : registered full flag from the FIFO write-pointer logic
//   winc     : write strobe to the FIFO (never high while wfull is high)
//   wdata    : word written when winc=1, zero otherwise
//   ack      : one-hot, marks the requester whose word was consumed this cycle
//   gnt_id   : index of the current / most recent burst owner
//   busy     : high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4,
  localparam int IW      = $clog2(NREQ),
  localparam int CW      = $clog2(MAXBURST) + 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       ack,
  output logic [IW-1:0]         gnt_id,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   count_q, count_d;

  // Returns the first requester with a word ready, searching upward from
  // last+1 and wrapping. The caller only uses the result when |r is true.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
    return pick;
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    winc         = 1'b0;
    wdata        = '0;
    ack          = '0;

    unique case (state_q)
      IDLE: begin
        // Arbitration cycle: choose and register the owner, but write nothing.
        if (|req) begin
          gnt_id_d = rr_pick(req, last_owner_q);
          count_d  = '0;
          state_d  = BURST;
        end
      end

      BURST: begin
        // Only the owner's request line matters; other requesters wait.
        winc = req[gnt_id_q] & ~wfull;
        if (winc) begin
          ack[gnt_id_q] = 1'b1;
          wdata         = req_data[gnt_id_q*DSIZE +: DSIZE];
          count_d       = count_q + CW'(1);
          if (count_q == CW'(MAXBURST - 1)) begin
            state_d      = IDLE;
            last_owner_d = gnt_id_q;
          end
        end else if (!req[gnt_id_q]) begin
          // The owner ran dry. A full FIFO alone only stalls the burst.
          state_d      = IDLE;
          last_owner_d = gnt_id_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q      <= IDLE;
      gnt_id_q     <= '0;
      last_owner_q <= IW'(NREQ - 1);
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
    end
  end

  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAXBURST=4).
// A behavioural model tracks the burst owner, the words written in the
// current burst and the previous owner. From those it predicts every output
// each cycle. Each requester presents a numbered word sequence {id, seq}. The
// sequence advances only when that requester is acked. Matching wdata
// therefore also proves that each requester's words stay in order.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;
  localparam int IW       = $clog2(NREQ);

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       ack;
  logic [IW-1:0]         gnt_id;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req),
    .req_data(req_data),
    .wfull   (wfull),
    .winc    (winc),
    .wdata   (wdata),
    .ack     (ack),
    .gnt_id  (gnt_id),
    .busy    (busy)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit m_busy;
  int m_owner;
  int m_writes;
  int m_last;
  int seq [NREQ];

  // Outputs observed in the latest cycle, used by the directed steps.
  logic          o_winc, o_busy;
  logic [NREQ-1:0] o_ack;
  logic [IW-1:0] o_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DSIZE-1:0] word_of(input int i);
    return DSIZE'((i << 6) | (seq[i] & 63));
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = word_of(i);
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_writes = 0;
    m_last   = NREQ - 1;
  endtask

  // Called at time posedge+1. Holds reset through one edge and releases it.
  task automatic do_reset();
    wrst  = 1'b1;
    req   = '0;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    drive_data();
    model_reset();
    #1;
    check("rst_busy",  32'(busy),   0);
    check("rst_winc",  32'(winc),   0);
    check("rst_ack",   32'(ack),    0);
    check("rst_wdata", 32'(wdata),  0);
    check("rst_gnt",   32'(gnt_id), 0);
    @(posedge wclk); #1;
    wrst = 1'b0;
  endtask

  // One clock cycle: drive the inputs, compare the outputs at the negedge with
  // the model, then advance the model at the posedge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic f);
    logic            e_winc;
    logic [NREQ-1:0] e_ack;
    logic [DSIZE-1:0] e_wdata;
    int              idx;
    req   = r;
    wfull = f;
    drive_data();
    @(negedge wclk);
    e_winc  = m_busy && r[m_owner] && !f;
    e_ack   = e_winc ? NREQ'(1 << m_owner) : '0;
    e_wdata = e_winc ? word_of(m_owner) : '0;
    check("busy",  32'(busy),  32'(m_busy));
    check("gnt",   32'(gnt_id), 32'(m_owner));
    check("winc",  32'(winc),  32'(e_winc));
    check("ack",   32'(ack),   32'(e_ack));
    check("wdata", 32'(wdata), 32'(e_wdata));
    check("winc_and_wfull", 32'(winc & wfull), 0);
    check("ack_onehot0", 32'($onehot0(ack)), 1);
    o_winc = winc; o_busy = busy; o_ack = ack; o_gnt = gnt_id;

    if (!m_busy) begin
      if (r != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (r[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_writes = 0;
        m_busy   = 1'b1;
      end
    end else if (e_winc) begin
      seq[m_owner]++;
      m_writes++;
      if (m_writes == MAXBURST) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
    @(posedge wclk); #1;
  endtask

  initial begin
    int order [$];
    int wr_cnt [$];
    logic prev_busy;
    int nwr;

    wrst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
    @(posedge wclk); #1;

    // Single requester 0: one arbitration cycle, four writes, then idle.
    do_reset();
    cycle(4'b0001, 1'b0);
    check("r032_c1_busy", 32'(o_busy), 0);
    check("r032_c1_winc", 32'(o_winc), 0);
    for (int c = 2; c <= 5; c++) begin
      cycle(4'b0001, 1'b0);
      check("r032_winc", 32'(o_winc), 1);
      check("r032_ack",  32'(o_ack),  32'h1);
    end
    cycle(4'b0001, 1'b0);
    check("r032_c6_busy", 32'(o_busy), 0);

    // All requesters held: grants go 0,1,2,3,0 with four writes each.
    do_reset();
    prev_busy = 1'b0;
    nwr = 0;
    for (int c = 0; c < 26; c++) begin
      cycle(4'b1111, 1'b0);
      if (o_busy && !prev_busy) order.push_back(int'(o_gnt));
      if (!o_busy && prev_busy) wr_cnt.push_back(nwr);
      if (o_busy && !prev_busy) nwr = 0;
      if (o_winc) nwr++;
      prev_busy = o_busy;
    end
    check("r033_nbursts", 32'(order.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("r033_order", 32'(order[i]), 32'(i % NREQ));
    for (int i = 0; i < 4 && i < wr_cnt.size(); i++)
      check("r033_writes", 32'(wr_cnt[i]), 32'(MAXBURST));

    // Owner 2 stalled by wfull for three cycles mid-burst.
    do_reset();
    cycle(4'b0100, 1'b0);
    nwr = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(4'b0100, 1'b0);
      if (o_winc) nwr++;
    end
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0101, 1'b1);
      check("r034_stall_winc", 32'(o_winc), 0);
      check("r034_stall_busy", 32'(o_busy), 1);
      check("r034_stall_gnt",  32'(o_gnt),  2);
    end
    for (int c = 0; c < 2; c++) begin
      cycle(4'b0101, 1'b0);
      if (o_winc) nwr++;
    end
    check("r034_total", 32'(nwr), 32'(MAXBURST));
    cycle(4'b0000, 1'b0);
    check("r034_idle", 32'(o_busy), 0);

    // Owner 1 drops its request after two writes; requester 2 is next.
    do_reset();
    cycle(4'b0010, 1'b0);
    cycle(4'b0110, 1'b0);
    cycle(4'b0110, 1'b0);
    check("r035_gnt1", 32'(o_gnt), 1);
    cycle(4'b0100, 1'b0);
    check("r035_drop_winc", 32'(o_winc), 0);
    cycle(4'b0101, 1'b0);
    check("r035_idle", 32'(o_busy), 0);
    cycle(4'b0101, 1'b0);
    check("r035_next_gnt", 32'(o_gnt), 2);
    check("r035_next_busy", 32'(o_busy), 1);

    // Reset asserted during owner 3's second write.
    do_reset();
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    req = 4'b1000; wfull = 1'b0; drive_data();
    #2;
    check("r036_pre_winc", 32'(winc), 1);
    wrst = 1'b1;
    #1;
    check("r036_winc", 32'(winc), 0);
    check("r036_ack",  32'(ack),  0);
    check("r036_busy", 32'(busy), 0);
    model_reset();
    @(posedge wclk); #1;
    wrst = 1'b0;
    cycle(4'b1001, 1'b0);
    check("r036_post_idle", 32'(o_winc), 0);
    cycle(4'b1001, 1'b0);
    check("r036_gnt0", 32'(o_gnt), 0);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 10000; c++)
      cycle(NREQ'($urandom), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
